cfu_issue: RTL
==============

# cfu_issue

Core-side initiator for the custom function unit (CFU) port. It sits in the execute stage, accepts a decoded custom instruction and drives the CFU valid/ctrl/operand interface. It holds the pipeline while the CFU asserts stall, captures the result, and presents it to writeback with its destination register. An optional watchdog bounds how long a CFU may stall.

## Interface
- XLEN, default `XLEN (32): operand/result width
- CTRL_W, default `CFU_CTRL_WIDTH: CFU control field width
- TIMEOUT_CYCLES, default 256: watchdog limit in REQ cycles; legal range ≥ 1 (only used with CFU_TIMEOUT_EN)

Ports:
- clk_i  in  1  sole clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- issue_valid_i  in  1  custom instruction present in EX
- issue_ctrl_i  in  CTRL_W  CFU control field
- issue_src1_i  in  XLEN  rs1 value
- issue_src2_i  in  XLEN  rs2 value
- issue_rd_i  in  5  destination register
- pipe_stall_i  in  1  downstream (writeback) stall
- pipe_flush_i  in  1  squash current instruction
- busy_o  out  1  hold EX stage
- done_o  out  1  result valid for writeback
- rslt_o  out  XLEN  captured result
- rd_o  out  5  destination of rslt_o
- timeout_o  out  1  completion was forced by the watchdog
- cfu_valid_o  out  1  request to CFU
- cfu_ctrl_o  out  CTRL_W  to CFU
- cfu_src1_o  out  XLEN  to CFU
- cfu_src2_o  out  XLEN  to CFU
- cfu_stall_o  out  1  freeze request to CFU
- cfu_stall_i  in  1  CFU not ready
- cfu_rslt_i  in  XLEN  CFU result, valid when cfu_valid_o=1 and cfu_stall_i=0

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE:**
  - When issue_valid_i=1 and pipe_flush_i=0, latch ctrl, src1, src2 and rd into registers, then go to REQ.
  - When issue_valid_i=1 and pipe_flush_i=1, accept nothing.
- **REQ:**
  - cfu_valid_o=1; cfu_ctrl_o, cfu_src1_o and cfu_src2_o are driven from the latched registers and are stable for the whole state.
  - When cfu_stall_i=0, the handshake completes. Capture cfu_rslt_i into rslt_o and go to DONE.
- **DONE:**
  - done_o=1; rslt_o and rd_o are held.
  - When pipe_stall_i=0, the result is consumed and the FSM goes to IDLE.
  - issue_valid_i is ignored in DONE.
- **busy_o** = (IDLE & issue_valid_i & ~pipe_flush_i) | REQ. It is 0 in DONE, so the instruction retires.
- **cfu_stall_o** = pipe_stall_i & ~REQ. The issue unit never freezes a CFU while a handshake it owns is open.
- **Flush while in REQ:**
  - The handshake is not aborted; cfu_valid_o stays high until cfu_stall_i=0.
  - A sticky squash bit is set. When the handshake completes, the result is discarded, the FSM goes directly to IDLE and done_o never asserts.
  - While squashed, busy_o=0.
- **Flush while in DONE:** done_o drops in the same cycle and the FSM goes to IDLE next cycle.
- **Flush and handshake completion in the same REQ cycle:** the squash wins and there is no done_o.

## Timing
- Reset (rst_ni=0, asynchronous) sets state=IDLE and clears squash and the counter. All outputs are 0: busy_o=0, done_o=0, rslt_o=0, rd_o=0, timeout_o=0, cfu_valid_o=0, cfu_ctrl_o=0, cfu_src1_o=0, cfu_src2_o=0, cfu_stall_o=0.
- Reset mid-transaction drops cfu_valid_o immediately. The CFU must tolerate a reset-aborted request.
- Minimum latency with a single-cycle CFU:
  - Cycle 0: issue accepted.
  - Cycle 1: cfu_valid_o=1.
  - Cycle 2: done_o=1.
- Each additional cfu_stall_i=1 cycle in REQ adds one cycle of latency.
- Back-to-back: the earliest next acceptance is the cycle after DONE is consumed, i.e. 3 cycles per operation.
- done_o is level-held across pipe_stall_i. It is consumed on exactly one clock edge.

## Configuration
- CFU_TIMEOUT_EN defined:
  - An internal counter clears on entry to REQ and increments in each REQ cycle with cfu_stall_i=1.
  - On the cycle the counter reaches TIMEOUT_CYCLES, cfu_valid_o drops, rslt_o is loaded with 0 and the FSM goes to DONE with timeout_o=1.
  - timeout_o is held with done_o. A squashed transaction times out silently: IDLE, with neither done_o nor timeout_o.
- CFU_TIMEOUT_EN undefined: no counter is built, REQ waits indefinitely, and timeout_o is tied to 0.

## Test plan
- **Single-cycle CFU:** issue ctrl=1, src1=5, src2=7, rd=3 with cfu_stall_i=0 and cfu_rslt_i=1 → cfu_valid_o high cycle 1 only; done_o=1, rslt_o=1, rd_o=3 in cycle 2; busy_o high in cycles 0–1.
- **Multi-cycle CFU:** cfu_stall_i=1 for 4 REQ cycles, then cfu_rslt_i=0xDEADBEEF → operands stable for 5 cycles, done_o in cycle 6 with rslt_o=0xDEADBEEF.
- **Writeback stall:** pipe_stall_i=1 for 3 cycles while in DONE → done_o, rslt_o and rd_o held 3 cycles; IDLE after the first cycle with pipe_stall_i=0; cfu_stall_o=1 in those cycles.
- **Flush in REQ** with cfu_stall_i=1 for 2 more cycles → cfu_valid_o held until the stall clears, busy_o=0 after the flush, no done_o, then IDLE.
- **Watchdog (CFU_TIMEOUT_EN, TIMEOUT_CYCLES=8):** cfu_stall_i stuck at 1 → cfu_valid_o drops after 8 REQ cycles; done_o=1, timeout_o=1, rslt_o=0.
- **Reset:** rst_ni low during REQ → all outputs 0 asynchronously; after release, the next issue completes normally.

Source files
------------

// File: rtl/cfu_issue.sv
// cfu_issue -- execute-stage initiator for the custom function unit port.
//
// Takes a decoded custom instruction from EX, latches its operands, runs one
// valid/stall handshake with the CFU, and presents the captured result with
// its destination register to writeback.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   issue_*_i              instruction from EX (valid, ctrl, rs1, rs2, rd)
//   pipe_stall_i           writeback not ready
//   pipe_flush_i           squash the current instruction
//   busy_o                 hold EX while the request is open
//   done_o, rslt_o, rd_o   result for writeback (level-held until consumed)
//   timeout_o              completion forced by the watchdog
//   cfu_valid_o/ctrl_o/src1_o/src2_o   request to the CFU
//   cfu_stall_o            freeze request to the CFU
//   cfu_stall_i, cfu_rslt_i            CFU response
//
// Build option: define CFU_TIMEOUT_EN to build the stall watchdog
// (TIMEOUT_CYCLES stalled REQ cycles, then complete with rslt_o=0, timeout_o=1).
// Without it the request waits indefinitely and timeout_o is 0.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef CFU_CTRL_WIDTH
`define CFU_CTRL_WIDTH 10
`endif

module cfu_issue #(
  parameter int XLEN           = `XLEN,
  parameter int CTRL_W         = `CFU_CTRL_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [CTRL_W-1:0] issue_ctrl_i,
  input  logic [XLEN-1:0]   issue_src1_i,
  input  logic [XLEN-1:0]   issue_src2_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              pipe_stall_i,
  input  logic              pipe_flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rslt_o,
  output logic [4:0]        rd_o,
  output logic              timeout_o,
  output logic              cfu_valid_o,
  output logic [CTRL_W-1:0] cfu_ctrl_o,
  output logic [XLEN-1:0]   cfu_src1_o,
  output logic [XLEN-1:0]   cfu_src2_o,
  output logic              cfu_stall_o,
  input  logic              cfu_stall_i,
  input  logic [XLEN-1:0]   cfu_rslt_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cfu_issue: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   src1_q, src2_q, rslt_q;
  logic [4:0]        rd_q;
  logic              squash_q, to_q;
  logic              accept, hs_done, tmo_hit, kill, leave_req;

  assign accept    = (state_q == IDLE) && issue_valid_i && !pipe_flush_i;
  assign hs_done   = (state_q == REQ) && !cfu_stall_i;
  // A flush in the completing cycle counts as a squash, so the result is dropped.
  assign kill      = squash_q || pipe_flush_i;
  assign leave_req = hs_done || tmo_hit;

`ifdef CFU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the number of stalled REQ cycles already seen; the watchdog
  // fires in the stalled cycle that would bring it to TIMEOUT_CYCLES.
  assign tmo_hit = (state_q == REQ) && cfu_stall_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                cnt_q <= '0;
    else if (state_q != REQ)    cnt_q <= '0;
    else if (cfu_stall_i)       cnt_q <= cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (leave_req) state_d = kill ? IDLE : DONE;
      DONE:    if (pipe_flush_i || !pipe_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      rd_q     <= '0;
      rslt_q   <= '0;
      squash_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q <= issue_ctrl_i;
        src1_q <= issue_src1_i;
        src2_q <= issue_src2_i;
        rd_q   <= issue_rd_i;
      end
      if (leave_req && !kill) begin
        rslt_q <= tmo_hit ? '0 : cfu_rslt_i;
        to_q   <= tmo_hit;
      end
      // Squash is sticky only while the handshake is still open.
      if (state_q != REQ || leave_req) squash_q <= 1'b0;
      else if (pipe_flush_i)           squash_q <= 1'b1;
    end
  end

  // rst_ni gates the terms fed straight from inputs so every output is 0 in reset.
  assign busy_o      = rst_ni && (accept || (state_q == REQ && !squash_q));
  assign cfu_stall_o = rst_ni && pipe_stall_i && (state_q != REQ);
  assign done_o      = (state_q == DONE) && !pipe_flush_i;
  assign timeout_o   = done_o && to_q;
  assign rslt_o      = rslt_q;
  assign rd_o        = rd_q;
  assign cfu_valid_o = (state_q == REQ);
  assign cfu_ctrl_o  = ctrl_q;
  assign cfu_src1_o  = src1_q;
  assign cfu_src2_o  = src2_q;

endmodule
